// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter family.
// Holds the default widths and the helpers that size the accumulator and
// give the saturation limits for a signed output of a given width.
package fir_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 8;
  localparam int OUT_W_DEF  = 16;
  localparam int TAPS_DEF   = 5;

  // Room for TAPS full-precision products, so the sum never overflows.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational rounding right-shift followed by saturation to OUT_W.
// Ports:
//   acc_i  - signed accumulator, ACC_W bits
//   y_o    - rounded, saturated result, OUT_W bits signed
//   clip_o - high when y_o was clipped to the max or min limit
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W = 19,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] y_o,
  output logic             clip_o
);

  // Internal width: holds acc plus the rounding bias and both output limits.
  localparam int EW = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;
  localparam logic signed [EW-1:0] MAX_V = EW'(sat_max(OUT_W));
  localparam logic signed [EW-1:0] MIN_V = EW'(sat_min(OUT_W));

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] r;

  assign ext = {{(EW - ACC_W){acc_i[ACC_W-1]}}, acc_i};

  generate
    if (SHIFT > 0) begin : g_round
      // Round half up: add half an output LSB, then floor-shift.
      localparam logic signed [EW-1:0] HALF = EW'(longint'(1) <<< (SHIFT - 1));
      assign r = (ext + HALF) >>> SHIFT;
    end else begin : g_pass
      assign r = ext;
    end
  endgenerate

  always_comb begin
    y_o    = r[OUT_W-1:0];
    clip_o = 1'b0;
    if (r > MAX_V) begin
      y_o    = MAX_V[OUT_W-1:0];
      clip_o = 1'b1;
    end else if (r < MIN_V) begin
      y_o    = MIN_V[OUT_W-1:0];
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/fir_filter_param.sv
// Programmable-coefficient direct-form FIR filter.
// Valid-qualified delay line, registered products, then a sum/round/saturate
// stage. A sample accepted at edge t gives out_valid after edge t+2.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   coef_we/addr/data   - coefficient write port (addr >= TAPS ignored)
//   in_valid, x_in      - input sample and its qualifier
//   out_valid, y_out    - filtered result and its qualifier
//   sat_flag            - y_out was clipped (qualified by out_valid)
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        x_in,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         y_out,
  output logic                     sat_flag
);

  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

  logic signed [DATA_W-1:0] tap_q      [TAPS];
  logic signed [DATA_W-1:0] tap_d      [TAPS];
  logic signed [COEF_W-1:0] coef_q     [TAPS];
  logic signed [COEF_W-1:0] coef_d     [TAPS];
  // Bank as it was one cycle earlier: a sample taken in the same cycle as a
  // write is multiplied by the coefficient that was in force when it arrived.
  logic signed [COEF_W-1:0] coef_use_q [TAPS];
  logic signed [PW-1:0]     p_q        [TAPS];
  logic signed [PW-1:0]     p_d        [TAPS];

  logic                     v0_q, v1_q, out_valid_q, sat_q;
  logic [OUT_W-1:0]         y_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic [OUT_W-1:0]         r_d;
  logic                     clip_d;

  generate
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
      if (k == 0) begin : g_head
        assign tap_d[k] = in_valid ? $signed(x_in) : tap_q[k];
      end else begin : g_body
        assign tap_d[k] = in_valid ? tap_q[k-1] : tap_q[k];
      end
      assign coef_d[k] = (coef_we && (coef_addr == AW'(k))) ? $signed(coef_data) : coef_q[k];
      assign p_d[k]    = PW'(tap_q[k]) * PW'(coef_use_q[k]);
    end
  endgenerate

  always_comb begin
    acc_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_d = acc_d + ACC_W'(p_q[k]);
    end
  end

  fir_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc_i  (acc_d),
    .y_o    (r_d),
    .clip_o (clip_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q       <= '{default: '0};
      coef_q      <= '{default: '0};
      coef_use_q  <= '{default: '0};
      p_q         <= '{default: '0};
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      coef_q      <= coef_d;
      coef_use_q  <= coef_q;
      p_q         <= p_d;
      v0_q        <= in_valid;
      v1_q        <= v0_q;
      out_valid_q <= v1_q;
      if (v1_q) begin
        y_q   <= r_d;
        sat_q <= clip_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign sat_flag  = sat_q;

endmodule

// File: doc/fir_filter_param.md
Name: fir_filter_param

Overview:
Parametrised, programmable-coefficient direct-form FIR filter. It is the next generation of the fixed 5-tap 8-bit FIR in the filter path.
- Generalised in tap count and data/coefficient/output widths.
- Coefficients are runtime-writable.
- Input is valid-qualified, so the delay line advances only on real samples.
- Two-stage pipeline with rounding right-shift and output saturation; a saturation flag is reported.

Parameters:
- DATA_W, 8, signed input sample width
- COEF_W, 8, signed coefficient width
- TAPS, 5, number of taps (>=2)
- OUT_W, 16, signed output width
- SHIFT, 0, arithmetic right-shift applied to the accumulator before saturation (0 = none)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index to write
- coef_data  in  COEF_W  signed coefficient value
- in_valid  in  1  x_in holds a sample this cycle
- x_in  in  DATA_W  signed input sample
- out_valid  out  1  y_out holds a new result this cycle
- y_out  out  OUT_W  signed filtered output
- sat_flag  out  1  y_out was clipped; qualified by out_valid

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. No asynchronous logic.
- Reset values:
  - delay line, coefficient bank, product registers and y_out all 0
  - out_valid and sat_flag 0
  - pipeline valid bits cleared
  - reset mid-stream discards all in-flight samples, so no out_valid appears for them
- Delay line: tap[0..TAPS-1]. On in_valid=1, tap[0]<=x_in and tap[k]<=tap[k-1]. On in_valid=0, the delay line holds.
- Stage 1 (cycle after the accepted sample): register product p[k] = tap[k]*coef[k], full precision, DATA_W+COEF_W bits signed; also register v1<=in_valid.
  - Products use the post-shift delay line, so the new x_in is at tap[0].
- Stage 2:
  - acc = sign-extended sum of p[k], width ACC_W = DATA_W+COEF_W+$clog2(TAPS). No internal overflow is possible.
  - If SHIFT>0: r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up). Otherwise r = acc.
  - Saturate r to OUT_W: r > 2^(OUT_W-1)-1 gives max, r < -2^(OUT_W-1) gives min; sat_flag=1 when either clip occurs.
  - Register y_out and sat_flag.
  - out_valid<=v1.
- Latency: a sample accepted at edge t produces its result with out_valid=1 after edge t+2. Throughput is one sample per clock. Bubbles in in_valid propagate as out_valid=0 with the same spacing.
- y_out and sat_flag hold their last values while out_valid=0.
- Coefficient write:
  - On coef_we=1, coef[coef_addr]<=coef_data at the edge.
  - A sample accepted in the same cycle as a write uses the old coefficient in stage 1. The new value applies from the next cycle's products.
  - coef_addr >= TAPS is ignored (no write).
- Simultaneous coef_we and rst: reset wins.
- No backpressure. The downstream must accept every out_valid.

Decomposition:
- Package fir_pkg:
  - default widths (DATA_W_DEF=8, COEF_W_DEF=8, OUT_W_DEF=16, TAPS_DEF=5)
  - function acc_width(data_w, coef_w, taps)
  - function sat_max/sat_min(out_w)
- One sub-module, fir_round_sat: combinational rounding shift plus saturation, parametrised by ACC_W, OUT_W and SHIFT. It outputs the value and the clip bit and is reused by future decimators.
- Delay line, coefficient bank and products stay in the top module as generate loops.

Test Plan:
1. Impulse response:
   - Stimulus: load coefs 16,32,48,16,16 (SHIFT=0); in_valid every cycle with x_in=1 then 0s.
   - Response: y_out = 16,32,48,16,16,0 on consecutive out_valid cycles, first one 2 edges after the impulse; sat_flag=0.
2. Bubbles:
   - Stimulus: same coefs; impulse then in_valid toggling 1,0,1,0 with x_in=0.
   - Response: out_valid pattern mirrors in_valid delayed by 2; y_out sequence is unchanged; the delay line does not advance on idle cycles.
3. Saturation:
   - Stimulus: all coefs 127, five consecutive x_in=127.
   - Response: the fifth output saturates at 32767 with sat_flag=1 (sum 80645).
   - Stimulus: coefs 127, x_in=-128 ×5.
   - Response: -32768 with sat_flag=1.
4. Rounding (SHIFT=4):
   - coef[0]=16, others 0, x_in=3 → y_out=3.
   - coef[0]=8, x_in=-1: acc=-8, +8=0 → y_out=0.
   - coef[0]=8, x_in=1: acc=8, +8=16 → y_out=1.
5. Write/sample collision:
   - Stimulus: coef[0]=1; same cycle assert coef_we addr0 data 5 and in_valid x_in=2, then x_in=2 again.
   - Response: outputs 2 then 10+(contribution of the older 2 via coef[1]).
   - Stimulus: write with addr=TAPS.
   - Response: no change.
6. Reset mid-stream:
   - Stimulus: stream nonzero samples; assert rst for 1 cycle with one sample in flight.
   - Response: no out_valid for in-flight samples; y_out=0; coefs=0; the first post-reset sample's output reflects an all-zero history.
